// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file writeback scheduler.
package rf_pkg;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef enum logic {MEM_PRI, ALU_PRI} wb_arb_e;

  typedef struct packed {
    logic [REG_AW-1:0] wreg;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard of reserved destination registers, hazard check ports and
// the sticky unreserved-commit flag.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = rf_pkg::NREG,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_reg,
  output logic            issue_ready,
  input  logic [AW-1:0]   chk_reg_1,
  input  logic [AW-1:0]   chk_reg_2,
  output logic            chk_busy_1,
  output logic            chk_busy_2,
  input  logic            commit_valid,
  input  logic [AW-1:0]   commit_reg,
  output logic [NREG-1:0] busy_vec,
  output logic            err_unreserved
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  assign issue_ready = rst_n && !busy_q[issue_reg];
  assign chk_busy_1  = busy_q[chk_reg_1];
  assign chk_busy_2  = busy_q[chk_reg_2];
  assign busy_vec    = busy_q;

  // Register 0 is never reserved, so bit 0 can never be set.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && issue_ready && (issue_reg != ZERO_REG))
      set_mask[issue_reg] = 1'b1;
    if (commit_valid)
      clr_mask[commit_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q         <= '0;
      err_unreserved <= 1'b0;
    end else begin
      busy_q <= (busy_q & ~clr_mask) | set_mask;
      if (commit_valid && !busy_q[commit_reg])
        err_unreserved <= 1'b1;
    end
  end

endmodule

// File: rtl/rf_write_sched.sv
// Arbitrates the single RF write port between ALU and load writeback, with
// ALU anti-starvation, a one-stage registered write path and a busy scoreboard.
module rf_write_sched
  import rf_pkg::*;
#(
  parameter int DATA_W       = rf_pkg::DATA_W,
  parameter int NREG         = rf_pkg::NREG,
  parameter int STARVE_LIMIT = 3,
  localparam int AW          = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_reg,
  output logic              issue_ready,
  input  logic [AW-1:0]     chk_reg_1,
  input  logic [AW-1:0]     chk_reg_2,
  output logic              chk_busy_1,
  output logic              chk_busy_2,
  input  logic              alu_valid,
  input  logic [AW-1:0]     alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [AW-1:0]     mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              rf_reg_write,
  output logic [AW-1:0]     rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [NREG-1:0]   busy_vec,
  output logic              err_unreserved
);

  localparam logic [3:0] LIMIT4 = 4'(STARVE_LIMIT);

  wb_arb_e    state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       alu_grant, mem_grant;
  wb_req_t    sel;

  // Loads win by default; once the ALU has been denied LIMIT times in a row
  // the ALU gets one cycle of priority.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (rst_n) begin
      case (state_q)
        MEM_PRI: begin
          mem_grant = mem_valid;
          alu_grant = alu_valid && !mem_valid;
          if (alu_grant) begin
            cnt_d = 4'd0;
          end else if (alu_valid) begin
            if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
            if (cnt_d == LIMIT4) state_d = ALU_PRI;
          end
        end
        ALU_PRI: begin
          alu_grant = alu_valid;
          mem_grant = mem_valid && !alu_valid;
          cnt_d     = 4'd0;
          state_d   = MEM_PRI;
        end
        default: state_d = MEM_PRI;
      endcase
    end
  end

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;
  assign sel       = alu_grant ? {alu_reg, alu_data} : {mem_reg, mem_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_PRI;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Writes to r0 complete the handshake but never strobe the RF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_reg_write  <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
    end else begin
      rf_reg_write <= (alu_grant || mem_grant) && (sel.wreg != ZERO_REG);
      if (alu_grant || mem_grant) begin
        rf_write_reg  <= sel.wreg;
        rf_write_data <= sel.data;
      end
    end
  end

  rf_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (issue_valid),
    .issue_reg      (issue_reg),
    .issue_ready    (issue_ready),
    .chk_reg_1      (chk_reg_1),
    .chk_reg_2      (chk_reg_2),
    .chk_busy_1     (chk_busy_1),
    .chk_busy_2     (chk_busy_2),
    .commit_valid   (rf_reg_write),
    .commit_reg     (rf_write_reg),
    .busy_vec       (busy_vec),
    .err_unreserved (err_unreserved)
  );

endmodule

// File: tb/tb_rf_write_sched.sv
// Randomized and directed bench for rf_write_sched with a queue scoreboard
// fed by a behavioural arbitration/reservation model.
module tb_rf_write_sched;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_reg = '0;
  logic        issue_ready;
  logic [4:0]  chk_reg_1 = '0, chk_reg_2 = '0;
  logic        chk_busy_1, chk_busy_2;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_reg = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_reg = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic        rf_reg_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [31:0] busy_vec;
  logic        err_unreserved;

  always #5 clk = ~clk;

  rf_write_sched #(.DATA_W(32), .NREG(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
    .chk_reg_1(chk_reg_1), .chk_reg_2(chk_reg_2),
    .chk_busy_1(chk_busy_1), .chk_busy_2(chk_busy_2),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .busy_vec(busy_vec), .err_unreserved(err_unreserved)
  );

  typedef struct { logic [4:0] r; logic [31:0] d; } wr_t;

  int checks = 0;
  int failures = 0;
  wr_t exp_q[$];

  // Reference state: reserved set, sticky error, ALU denial streak and the
  // write that becomes visible on the RF port next cycle.
  logic [31:0] m_busy;
  bit          m_err;
  int          waited;
  bit          pend_v;
  logic [4:0]  pend_r;
  bit          g_alu, g_mem, g_issue;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_busy = '0;
    m_err  = 1'b0;
    waited = 0;
    pend_v = 1'b0;
    exp_q.delete();
  endtask

  // One cycle: drive at the falling edge, check, then advance the model
  // across the coming rising edge.
  task automatic applyStimulus(input bit iv, input logic [4:0] ir,
                               input logic [4:0] c1, input logic [4:0] c2,
                               input bit av, input logic [4:0] ar, input logic [31:0] ad,
                               input bit mv, input logic [4:0] mr, input logic [31:0] md);
    bit ir_exp, pri;
    wr_t w;
    @(negedge clk);
    issue_valid = iv; issue_reg = ir; chk_reg_1 = c1; chk_reg_2 = c2;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    #1;
    pri    = (waited >= LIMIT);
    ir_exp = rst_n && ((ir == 5'd0) || !m_busy[ir]);
    if (!rst_n) begin
      g_alu = 1'b0; g_mem = 1'b0;
    end else if (pri) begin
      g_alu = av; g_mem = mv && !av;
    end else begin
      g_mem = mv; g_alu = av && !mv;
    end
    g_issue = iv && ir_exp;
    checkOutput("issue_ready", 32'(issue_ready), 32'(ir_exp));
    checkOutput("chk_busy_1", 32'(chk_busy_1), 32'(m_busy[c1]));
    checkOutput("chk_busy_2", 32'(chk_busy_2), 32'(m_busy[c2]));
    checkOutput("alu_ready", 32'(alu_ready), 32'(g_alu));
    checkOutput("mem_ready", 32'(mem_ready), 32'(g_mem));
    checkOutput("busy_vec", busy_vec, m_busy);
    checkOutput("err_unreserved", 32'(err_unreserved), 32'(m_err));
    if (!rst_n) return;
    if (pri || g_alu) waited = 0;
    else if (av && waited < 15) waited++;
    if (pend_v) begin
      if (!m_busy[pend_r]) m_err = 1'b1;
      m_busy[pend_r] = 1'b0;
    end
    if (g_issue && ir != 5'd0) m_busy[ir] = 1'b1;
    pend_v = 1'b0;
    if (g_alu || g_mem) begin
      w.r = g_alu ? ar : mr;
      w.d = g_alu ? ad : md;
      if (w.r != 5'd0) begin
        exp_q.push_back(w);
        pend_v = 1'b1;
        pend_r = w.r;
      end
    end
  endtask

  task automatic idle(input logic [4:0] c1);
    applyStimulus(0, 0, c1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [4:0] pickReg();
    logic [4:0] r;
    if (m_busy != 0 && $urandom_range(3) != 0) begin
      for (int k = 0; k < 64; k++) begin
        r = 5'($urandom_range(31));
        if (m_busy[r]) return r;
      end
    end
    return 5'($urandom_range(31));
  endfunction

  // Monitor: every committed write must match the oldest expected one, and
  // no write may appear when nothing was granted the cycle before.
  initial begin : monitor
    wr_t w;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        checkOutput("rf_reg_write", 32'(rf_reg_write), 32'd1);
        if (rf_reg_write) begin
          checkOutput("rf_write_reg", 32'(rf_write_reg), 32'(w.r));
          checkOutput("rf_write_data", rf_write_data, w.d);
        end
      end else begin
        checkOutput("rf_reg_write_idle", 32'(rf_reg_write), 32'd0);
      end
    end
  end

  initial begin : stim
    bit a_v, m_v, i_v;
    logic [4:0] a_r, m_r, i_r;
    logic [31:0] a_d, m_d;
    logic [5:0] alu_pat;

    modelReset();
    #1 rst_n = 1'b0;

    // Reset with every request asserted: nothing granted, all outputs clear.
    repeat (3) applyStimulus(1, 5'd4, 5'd4, 5'd5, 1, 5'd6, 32'h11, 1, 5'd7, 32'h22);
    checkOutput("reset_rf_reg_write", 32'(rf_reg_write), 32'd0);
    checkOutput("reset_rf_write_reg", 32'(rf_write_reg), 32'd0);
    checkOutput("reset_rf_write_data", rf_write_data, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // First grant after reset goes to the load; r3 reserved on the same edge.
    applyStimulus(1, 5'd3, 5'd3, 0, 1, 5'd0, 32'h5, 1, 5'd3, 32'hCAFE0003);
    checkOutput("first_grant_mem", 32'(mem_ready), 32'd1);
    idle(5'd3);

    // Reserve r5, ALU writes it; busy until the RF commit edge.
    applyStimulus(1, 5'd5, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 5'd5, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    checkOutput("r5_busy_during_alu", 32'(chk_busy_1), 32'd1);
    idle(5'd5);
    checkOutput("r5_busy_at_commit", 32'(busy_vec[5]), 32'd1);
    idle(5'd5);
    checkOutput("r5_free_after_commit", 32'(chk_busy_1), 32'd0);

    // Both sources held: three load grants, then the ALU, then loads again.
    alu_pat = 6'b001000;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 5'd0, 32'(i), 1, 5'd0, 32'(i + 100));
      checkOutput("starve_pattern", 32'(alu_ready), 32'(alu_pat[i]));
    end
    idle(0);

    // Back-to-back reservations of r7.
    applyStimulus(1, 5'd7, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd7, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r7_second_issue_blocked", 32'(issue_ready), 32'd0);
    applyStimulus(1, 5'd7, 0, 0, 1, 5'd7, 32'h77, 0, 0, 0);
    applyStimulus(1, 5'd7, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r7_blocked_at_commit", 32'(issue_ready), 32'd0);
    applyStimulus(1, 5'd7, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r7_second_issue_accepted", 32'(issue_ready), 32'd1);

    // Write to r0 is swallowed; load to unreserved r9 raises the error.
    applyStimulus(0, 0, 0, 0, 1, 5'd0, 32'h1, 0, 0, 0);
    checkOutput("r0_alu_ready", 32'(alu_ready), 32'd1);
    idle(0);
    checkOutput("r0_no_rf_write", 32'(rf_reg_write), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 32'h99);
    idle(0);
    idle(0);
    checkOutput("err_after_unreserved", 32'(err_unreserved), 32'd1);

    // Randomized traffic honouring valid/ready hold rules.
    a_v = 0; m_v = 0; i_v = 0;
    a_r = 0; m_r = 0; i_r = 0; a_d = 0; m_d = 0;
    for (int n = 0; n < 400; n++) begin
      if (!a_v && $urandom_range(1) == 1) begin
        a_v = 1; a_r = pickReg(); a_d = $urandom;
      end
      if (!m_v && $urandom_range(2) == 0) begin
        m_v = 1; m_r = pickReg(); m_d = $urandom;
      end
      if (!i_v && $urandom_range(1) == 1) begin
        i_v = 1; i_r = 5'($urandom_range(31));
      end
      applyStimulus(i_v, i_r, 5'($urandom_range(31)), 5'($urandom_range(31)),
                    a_v, a_r, a_d, m_v, m_r, m_d);
      if (g_alu) a_v = 0;
      if (g_mem) m_v = 0;
      if (g_issue) i_v = 0;
    end

    // Reset while a write is on the RF port.
    applyStimulus(1, 5'd12, 0, 0, 1, 5'd12, 32'h12121212, 0, 0, 0);
    @(posedge clk);
    #2;
    checkOutput("pre_reset_write", 32'(rf_reg_write), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_write_drop", 32'(rf_reg_write), 32'd0);
    checkOutput("async_reset_busy_clear", busy_vec, 32'd0);
    modelReset();
    idle(0);
    @(posedge clk); #2 rst_n = 1'b1;
    applyStimulus(1, 5'd2, 5'd2, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 5'd2, 0, 0, 0, 0, 1, 5'd2, 32'hABCD0002);
    idle(5'd2);
    idle(5'd2);
    idle(0);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
